bram_pingpong_bank: RTL and testbench

//  Parametrised successor of the 54-bit/3x18 coefficient bank. Two-half (ping/pong)

---
 rtl/bram_pingpong_bank.sv | 169 ++++++++++++++++
 tb/tb_bram_pingpong_bank.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_pingpong_bank.sv
// Ping/pong coefficient buffer: DATA_WIDTH words are split across NSLICE BRAM slices.
// The loader fills one half while the butterfly read port drains the other.
module bram_pingpong_bank #(
    parameter int unsigned DATA_WIDTH  = 54,
    parameter int unsigned SLICE_WIDTH = 18,
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned RD_LATENCY  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_last,
    output logic                  rd_avail,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_done,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  wr_drop,
    output logic                  rd_err
);

    localparam int unsigned NSLICE    = (DATA_WIDTH + SLICE_WIDTH - 1) / SLICE_WIDTH;
    localparam int unsigned PAD_WIDTH = NSLICE * SLICE_WIDTH;
    localparam int unsigned PTR_WIDTH = ADDR_WIDTH + 1;
    localparam int unsigned RAM_DEPTH = 2 ** PTR_WIDTH;

    typedef enum logic {
        HALF_EMPTY = 1'b0,
        HALF_FULL  = 1'b1
    } half_state_e;

    // Reset asserts asynchronously but releases on a clock edge.
    logic [1:0] rst_sync;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    half_state_e half_q [2];
    half_state_e half_d [2];
    logic        wsel_q;
    logic        wsel_d;
    logic        rsel_q;
    logic        rsel_d;
    logic        wr_ready_d;
    logic        rd_avail_d;
    logic        wr_acc;
    logic        rd_iss;
    logic        rd_rel;

    assign wr_acc = wr_valid && wr_ready;
    assign rd_iss = rd_en && rd_avail;
    assign rd_rel = rd_done && rd_avail;

    // Half state, select pointers and handshake outputs.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            half_q[0] <= HALF_EMPTY;
            half_q[1] <= HALF_EMPTY;
            wsel_q    <= 1'b0;
            rsel_q    <= 1'b0;
            wr_ready  <= 1'b1;
            rd_avail  <= 1'b0;
            wr_drop   <= 1'b0;
            rd_err    <= 1'b0;
        end else begin
            half_q   <= half_d;
            wsel_q   <= wsel_d;
            rsel_q   <= rsel_d;
            wr_ready <= wr_ready_d;
            rd_avail <= rd_avail_d;
            wr_drop  <= wr_drop || (wr_valid && !wr_ready);
            rd_err   <= rd_err || ((rd_en || rd_done) && !rd_avail);
        end
    end

    // A completed fill and a release always hit different halves, so both may apply.
    always_comb begin
        half_d = half_q;
        wsel_d = wsel_q;
        rsel_d = rsel_q;
        if (wr_acc && wr_last) begin
            half_d[wsel_q] = HALF_FULL;
            wsel_d         = ~wsel_q;
        end
        if (rd_rel) begin
            half_d[rsel_q] = HALF_EMPTY;
            rsel_d         = ~rsel_q;
        end
        wr_ready_d = (half_d[wsel_d] == HALF_EMPTY);
        rd_avail_d = (half_d[rsel_d] == HALF_FULL);
    end

    logic [PAD_WIDTH-1:0] wr_pad;
    logic [PAD_WIDTH-1:0] ram_q;
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;

    assign wr_pad = PAD_WIDTH'(wr_data);
    assign wr_ptr = {wsel_q, wr_addr};
    assign rd_ptr = {rsel_q, rd_addr};

    for (genvar k = 0; k < NSLICE; k++) begin : g_slice
        logic [SLICE_WIDTH-1:0] mem [RAM_DEPTH];
        logic [SLICE_WIDTH-1:0] rd_slice;

        always_ff @(posedge clk) begin
            if (wr_acc) begin
                mem[wr_ptr] <= wr_pad[k*SLICE_WIDTH +: SLICE_WIDTH];
            end
        end

        always_ff @(posedge clk or negedge rst_int_n) begin
            if (!rst_int_n) begin
                rd_slice <= '0;
            end else if (rd_iss) begin
                rd_slice <= mem[rd_ptr];
            end
        end

        assign ram_q[k*SLICE_WIDTH +: SLICE_WIDTH] = rd_slice;
    end

    logic rd_v1;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            rd_v1 <= 1'b0;
        end else begin
            rd_v1 <= rd_iss;
        end
    end

    if (RD_LATENCY == 1) begin : g_lat1
        assign rd_valid = rd_v1;
        assign rd_data  = ram_q[DATA_WIDTH-1:0];
    end else begin : g_lat2
        // Extra output register; data only moves when a word arrives so it holds otherwise.
        logic                  rd_valid_q;
        logic [DATA_WIDTH-1:0] rd_data_q;

        always_ff @(posedge clk or negedge rst_int_n) begin
            if (!rst_int_n) begin
                rd_valid_q <= 1'b0;
                rd_data_q  <= '0;
            end else begin
                rd_valid_q <= rd_v1;
                if (rd_v1) begin
                    rd_data_q <= ram_q[DATA_WIDTH-1:0];
                end
            end
        end

        assign rd_valid = rd_valid_q;
        assign rd_data  = rd_data_q;
    end

endmodule

// File: tb/tb_bram_pingpong_bank.sv
// Scoreboard bench: three banks (54b/lat2, 54b/lat1, 40b/lat2) share one stimulus stream;
// reads push expected words and a monitor pops them when each bank presents rd_valid.
module tb_bram_pingpong_bank;

    typedef struct {
        logic [53:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid;
    logic [9:0]  wr_addr;
    logic [53:0] wr_data;
    logic        wr_last;
    logic        rd_en;
    logic [9:0]  rd_addr;
    logic        rd_done;
    logic [39:0] wr_data_c;

    logic        wr_ready_a, rd_avail_a, rd_valid_a, wr_drop_a, rd_err_a;
    logic        wr_ready_b, rd_avail_b, rd_valid_b, wr_drop_b, rd_err_b;
    logic        wr_ready_c, rd_avail_c, rd_valid_c, wr_drop_c, rd_err_c;
    logic [53:0] rd_data_a;
    logic [53:0] rd_data_b;
    logic [39:0] rd_data_c;

    assign wr_data_c = wr_data[39:0];

    bram_pingpong_bank #(.DATA_WIDTH(54), .SLICE_WIDTH(18), .ADDR_WIDTH(10), .RD_LATENCY(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready_a), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_last(wr_last), .rd_avail(rd_avail_a), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_done(rd_done), .rd_valid(rd_valid_a), .rd_data(rd_data_a), .wr_drop(wr_drop_a), .rd_err(rd_err_a)
    );

    bram_pingpong_bank #(.DATA_WIDTH(54), .SLICE_WIDTH(18), .ADDR_WIDTH(10), .RD_LATENCY(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready_b), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_last(wr_last), .rd_avail(rd_avail_b), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_done(rd_done), .rd_valid(rd_valid_b), .rd_data(rd_data_b), .wr_drop(wr_drop_b), .rd_err(rd_err_b)
    );

    bram_pingpong_bank #(.DATA_WIDTH(40), .SLICE_WIDTH(18), .ADDR_WIDTH(10), .RD_LATENCY(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready_c), .wr_addr(wr_addr),
        .wr_data(wr_data_c), .wr_last(wr_last), .rd_avail(rd_avail_c), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_done(rd_done), .rd_valid(rd_valid_c), .rd_data(rd_data_c), .wr_drop(wr_drop_c), .rd_err(rd_err_c)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   total = 0;
    int   bad = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_rd(input string name, input logic [53:0] act, input exp_t e);
        total++;
        if (act !== e.data || cyc != e.due) begin
            bad++;
            $display("FAIL %s: got %0h at cycle %0d expected %0h at cycle %0d", name, act, cyc, e.data, e.due);
        end
    endtask

    task automatic unexpected(input string name, input logic [53:0] act);
        total++;
        bad++;
        $display("FAIL %s: unexpected rd_valid data %0h at cycle %0d, expected none", name, act, cyc);
    endtask

    // Called once per negedge: pop and compare for every bank presenting a word.
    task automatic monitor_sample();
        exp_t e;
        if (rd_valid_a) begin
            if (qa.size() == 0) unexpected("rd_a", rd_data_a);
            else begin e = qa.pop_front(); check_rd("rd_a", rd_data_a, e); end
        end
        if (rd_valid_b) begin
            if (qb.size() == 0) unexpected("rd_b", rd_data_b);
            else begin e = qb.pop_front(); check_rd("rd_b", rd_data_b, e); end
        end
        if (rd_valid_c) begin
            if (qc.size() == 0) unexpected("rd_c", 54'(rd_data_c));
            else begin e = qc.pop_front(); check_rd("rd_c", 54'(rd_data_c), e); end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic clear_in();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        rd_en    = 1'b0;
        rd_done  = 1'b0;
    endtask

    task automatic write(input logic [9:0] addr, input logic [53:0] data, input logic last);
        wr_valid = 1'b1;
        wr_addr  = addr;
        wr_data  = data;
        wr_last  = last;
        step();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    // Drives a read request for the coming edge and records the word each bank owes.
    task automatic push_read(input logic [9:0] addr, input logic [53:0] exp);
        exp_t e;
        rd_en   = 1'b1;
        rd_addr = addr;
        e.data  = exp;
        e.due   = cyc + 2;
        qa.push_back(e);
        e.due   = cyc + 1;
        qb.push_back(e);
        e.data  = 54'(exp[39:0]);
        e.due   = cyc + 2;
        qc.push_back(e);
    endtask

    task automatic check_state(input string tag, input logic wr, input logic ra, input logic drop, input logic err);
        check({tag, "_wr_ready_a"}, 64'(wr_ready_a), 64'(wr));
        check({tag, "_wr_ready_b"}, 64'(wr_ready_b), 64'(wr));
        check({tag, "_wr_ready_c"}, 64'(wr_ready_c), 64'(wr));
        check({tag, "_rd_avail_a"}, 64'(rd_avail_a), 64'(ra));
        check({tag, "_rd_avail_b"}, 64'(rd_avail_b), 64'(ra));
        check({tag, "_rd_avail_c"}, 64'(rd_avail_c), 64'(ra));
        check({tag, "_wr_drop_a"},  64'(wr_drop_a),  64'(drop));
        check({tag, "_wr_drop_b"},  64'(wr_drop_b),  64'(drop));
        check({tag, "_wr_drop_c"},  64'(wr_drop_c),  64'(drop));
        check({tag, "_rd_err_a"},   64'(rd_err_a),   64'(err));
        check({tag, "_rd_err_b"},   64'(rd_err_b),   64'(err));
        check({tag, "_rd_err_c"},   64'(rd_err_c),   64'(err));
    endtask

    task automatic check_no_valid(input string tag);
        check({tag, "_valid_a"}, 64'(rd_valid_a), 64'd0);
        check({tag, "_valid_b"}, 64'(rd_valid_b), 64'd0);
        check({tag, "_valid_c"}, 64'(rd_valid_c), 64'd0);
    endtask

    task automatic run();
        // Reset values
        rst_n = 1'b0;
        idle(3);
        check_state("rst", 1'b1, 1'b0, 1'b0, 1'b0);
        check_no_valid("rst");
        check("rst_data_a", 64'(rd_data_a), 64'd0);
        check("rst_data_c", 64'(rd_data_c), 64'd0);
        rst_n = 1'b1;
        idle(4);

        // Fill half 0 with addr*3
        for (int a = 0; a < 1024; a++) write(10'(a), 54'(a * 3), a == 1023);
        check_state("fill0", 1'b1, 1'b1, 1'b0, 1'b0);

        // Latency and hold-last-value
        push_read(10'd5, 54'd15);
        step();
        rd_en = 1'b0;
        idle(3);
        check("hold_data_a", 64'(rd_data_a), 64'd15);
        check("hold_data_b", 64'(rd_data_b), 64'd15);
        check("hold_valid_a", 64'(rd_valid_a), 64'd0);
        push_read(10'd0, 54'd0);
        step();
        push_read(10'd1023, 54'd3069);
        step();
        push_read(10'd1, 54'd3);
        step();
        rd_en = 1'b0;
        idle(3);

        // Fill half 1, then a dropped write aimed at half 0
        for (int a = 0; a < 4; a++) write(10'(a), 54'(1000 + a), a == 3);
        check_state("both_full", 1'b0, 1'b1, 1'b0, 1'b0);
        write(10'd5, 54'h3F_FFFF_FFFF_FFFF, 1'b1);
        check_state("drop", 1'b0, 1'b1, 1'b1, 1'b0);
        push_read(10'd5, 54'd15);
        step();
        rd_en = 1'b0;
        idle(3);
        rd_done = 1'b1;
        check("pre_release_wr_ready_a", 64'(wr_ready_a), 64'd0);
        step();
        rd_done = 1'b0;
        check_state("release0", 1'b1, 1'b1, 1'b1, 1'b0);

        // Half 0 refill with simultaneous fill-complete, read and release of half 1
        write(10'd7, 54'hA5_1234_5678, 1'b0);
        push_read(10'd2, 54'd1002);
        rd_done  = 1'b1;
        wr_valid = 1'b1;
        wr_addr  = 10'd8;
        wr_data  = 54'h3F_FFFF_FFFF_FFFF;
        wr_last  = 1'b1;
        step();
        clear_in();
        check_state("swap_both", 1'b1, 1'b1, 1'b1, 1'b0);
        push_read(10'd7, 54'hA5_1234_5678);
        step();
        push_read(10'd8, 54'h3F_FFFF_FFFF_FFFF);
        step();
        rd_en = 1'b0;
        idle(3);

        // Read together with release, then a read with nothing available
        push_read(10'd7, 54'hA5_1234_5678);
        rd_done = 1'b1;
        step();
        clear_in();
        check_state("rd_en_done", 1'b1, 1'b0, 1'b1, 1'b0);
        idle(3);
        rd_en   = 1'b1;
        rd_addr = 10'd7;
        step();
        rd_en = 1'b0;
        idle(3);
        check_state("rd_err", 1'b1, 1'b0, 1'b1, 1'b1);

        // Reset with a read in flight
        write(10'd9, 54'd77, 1'b1);
        check_state("refill", 1'b1, 1'b1, 1'b1, 1'b1);
        push_read(10'd9, 54'd77);
        step();
        rd_en = 1'b0;
        check("inflight_qa", 64'(qa.size()), 64'd1);
        check("inflight_qb", 64'(qb.size()), 64'd1);
        rst_n = 1'b0;
        qa.delete();
        qb.delete();
        qc.delete();
        #1;
        check_no_valid("rst_flight");
        idle(3);
        rst_n = 1'b1;
        idle(4);
        check_state("post_rst", 1'b1, 1'b0, 1'b0, 1'b0);
        check_no_valid("post_rst");
        idle(3);
        check("end_qa", 64'(qa.size()), 64'd0);
        check("end_qb", 64'(qb.size()), 64'd0);
        check("end_qc", 64'(qc.size()), 64'd0);
    endtask

    initial begin
        clear_in();
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        fork
            begin
                forever begin
                    @(negedge clk);
                    if (rst_n) monitor_sample();
                end
            end
            begin
                run();
            end
        join_any
        disable fork;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
